// File: rtl/aes_kat_pkg.sv
// Shared definitions for the AES known-answer self-test: FSM encoding,
// table size and the layout of one known-answer vector.
package aes_kat_pkg;

  localparam int          NUM_KAT      = 7;
  localparam logic [2:0]  KAT_IDX_NONE = 3'd7;
  localparam logic [2:0]  KAT_IDX_LAST = 3'(NUM_KAT - 1);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_CRST  = 4'd1,
    ST_LOAD  = 4'd2,
    ST_START = 4'd3,
    ST_WAIT  = 4'd4,
    ST_CHECK = 4'd5,
    ST_DRAIN = 4'd6,
    ST_NEXT  = 4'd7,
    ST_DONE  = 4'd8
  } aes_kat_state_e;

  // One table entry: direction (1 = encrypt), operand, key and the
  // result the core must return for that operand/key pair.
  typedef struct packed {
    logic         enc_dec;
    logic [127:0] data;
    logic [127:0] key;
    logic [127:0] expected;
  } aes_kat_vec_t;

  function automatic aes_kat_vec_t kat_vec(input logic         enc_dec,
                                           input logic [127:0] data,
                                           input logic [127:0] key,
                                           input logic [127:0] expected);
    aes_kat_vec_t v;
    v.enc_dec  = enc_dec;
    v.data     = data;
    v.key      = key;
    v.expected = expected;
    return v;
  endfunction

endpackage

// File: rtl/aes_kat_rom.sv
// Combinational known-answer table: FIPS 197 C.1, Appendix B and the
// all-zero / all-ones AES-128 vectors. Unused indices read as all-zero.
module aes_kat_rom
  import aes_kat_pkg::*;
(
  input  logic [2:0]   idx_i,
  output aes_kat_vec_t vec_o
);

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] F_CT   = 128'hbcbf217cb280cf30b2517052193ab979;
  localparam logic [127:0] ALL0   = '0;
  localparam logic [127:0] ALL1   = '1;

  // Table lookup; decrypt entries swap operand and expected value.
  always_comb begin
    vec_o = '0;
    case (idx_i)
      3'd0:    vec_o = kat_vec(1'b1, C1_PT, C1_KEY, C1_CT);
      3'd1:    vec_o = kat_vec(1'b1, B_PT,  B_KEY,  B_CT);
      3'd2:    vec_o = kat_vec(1'b1, ALL0,  ALL0,   Z_CT);
      3'd3:    vec_o = kat_vec(1'b1, ALL1,  ALL1,   F_CT);
      3'd4:    vec_o = kat_vec(1'b0, C1_CT, C1_KEY, C1_PT);
      3'd5:    vec_o = kat_vec(1'b0, B_CT,  B_KEY,  B_PT);
      3'd6:    vec_o = kat_vec(1'b0, Z_CT,  ALL0,   ALL0);
      default: vec_o = '0;
    endcase
  end

endmodule

// File: rtl/aes_kat_selftest.sv
// Known-answer BIST initiator for aes_core_fixed. Walks the vector table,
// resetting the core before each vector, and accumulates pass/fail status.
//
// Core handshake: operands are presented and held from LOAD until DRAIN
// exits; core_start is a single-cycle pulse; the first cycle core_ready is
// seen high in WAIT (including the WAIT entry cycle) the result is taken,
// and the machine then waits for core_ready to fall before the next vector.
module aes_kat_selftest
  import aes_kat_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CRST_CYCLES    = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           pass_o,
  output logic [2:0]     fail_count_o,
  output logic [2:0]     first_fail_o,
  output logic           timeout_o,
  output logic           core_rst_n,
  output logic           core_start,
  output logic           core_enc_dec,
  output logic [127:0]   core_data_in,
  output logic [127:0]   core_key_in,
  input  logic [127:0]   core_data_out,
  input  logic           core_ready,
  output aes_kat_state_e dbg_state_o
);

  localparam int               CNT_W       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_CRST    = CNT_W'(CRST_CYCLES - 1);

  aes_kat_state_e   r_state;
  logic [2:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [127:0]     r_result;
  aes_kat_vec_t     w_vec;
  logic             w_mismatch;

  aes_kat_rom u_rom (
    .idx_i (r_idx),
    .vec_o (w_vec)
  );

  assign w_mismatch  = (r_result != w_vec.expected);
  assign dbg_state_o = r_state;

  // Self-test sequencer: every output is a register written here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_result     <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      pass_o       <= 1'b0;
      fail_count_o <= '0;
      first_fail_o <= KAT_IDX_NONE;
      timeout_o    <= 1'b0;
      core_rst_n   <= 1'b0;
      core_start   <= 1'b0;
      core_enc_dec <= 1'b0;
      core_data_in <= '0;
      core_key_in  <= '0;
    end else begin
      core_start <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          core_rst_n <= 1'b1;
          if (run_i) begin
            done_o       <= 1'b0;
            pass_o       <= 1'b0;
            fail_count_o <= '0;
            first_fail_o <= KAT_IDX_NONE;
            timeout_o    <= 1'b0;
            r_idx        <= '0;
            busy_o       <= 1'b1;
            core_rst_n   <= 1'b0;
            r_cnt        <= CNT_CRST;
            r_state      <= ST_CRST;
          end
        end
        ST_CRST: begin
          if (r_cnt == '0) begin
            // Operands are registered here so they are settled for the
            // whole LOAD cycle before core_start is raised.
            core_rst_n   <= 1'b1;
            core_enc_dec <= w_vec.enc_dec;
            core_data_in <= w_vec.data;
            core_key_in  <= w_vec.key;
            r_state      <= ST_LOAD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_LOAD: begin
          core_start <= 1'b1;
          r_state    <= ST_START;
        end
        ST_START: begin
          r_cnt   <= CNT_TIMEOUT;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_ready) begin
            r_result <= core_data_out;
            r_state  <= ST_CHECK;
          end else if (r_cnt == '0) begin
            fail_count_o <= fail_count_o + 3'd1;
            if (first_fail_o == KAT_IDX_NONE) first_fail_o <= r_idx;
            timeout_o <= 1'b1;
            r_state   <= ST_NEXT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_CHECK: begin
          if (w_mismatch) begin
            fail_count_o <= fail_count_o + 3'd1;
            if (first_fail_o == KAT_IDX_NONE) first_fail_o <= r_idx;
          end
          r_cnt   <= CNT_TIMEOUT;
          r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // A drain timeout flags the core but leaves the vector verdict alone.
          if (!core_ready) begin
            r_state <= ST_NEXT;
          end else if (r_cnt == '0) begin
            timeout_o <= 1'b1;
            r_state   <= ST_NEXT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_NEXT: begin
          if (r_idx == KAT_IDX_LAST) begin
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
            pass_o  <= (fail_count_o == '0);
            r_state <= ST_DONE;
          end else begin
            r_idx      <= r_idx + 3'd1;
            core_rst_n <= 1'b0;
            r_cnt      <= CNT_CRST;
            r_state    <= ST_CRST;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
